// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller with a shadow pipeline of destination tags.
// Optional statistics counters are enabled by defining HAZ_STATS_EN.
module pipe_hazard_ctrl #(
  parameter int XLEN          = 32,
  parameter int FWD_STAGES    = 3,
  parameter int LOAD_LAT      = 1,
  parameter int REDIRECT_SLOT = 1,
  localparam int SELW         = $clog2(FWD_STAGES + 1)
) (
  input  logic                       CLOCK,
  input  logic                       RST_n,
  input  logic                       hold,
  input  logic                       id_valid,
  input  logic                       id_regwrite,
  input  logic                       id_memread,
  input  logic                       id_use_rs1,
  input  logic                       id_use_rs2,
  input  logic [4:0]                 id_rs1,
  input  logic [4:0]                 id_rs2,
  input  logic [4:0]                 id_rd,
  input  logic [4:0]                 ex_rs1,
  input  logic [4:0]                 ex_rs2,
  input  logic [XLEN-1:0]            rf_a,
  input  logic [XLEN-1:0]            rf_b,
  input  logic [FWD_STAGES*XLEN-1:0] fwd_data,
  input  logic                       redirect,
  output logic                       pc_write,
  output logic                       ifid_write,
  output logic                       ifid_flush,
  output logic                       idex_bubble,
  output logic [SELW-1:0]            fwd_sel_a,
  output logic [SELW-1:0]            fwd_sel_b,
  output logic [XLEN-1:0]            ex_opa,
  output logic [XLEN-1:0]            ex_opb,
  output logic [31:0]                stall_count,
  output logic [31:0]                flush_count
);

  logic [FWD_STAGES:0] s_valid_r;
  logic [FWD_STAGES:0] s_regwrite_r;
  logic [FWD_STAGES:0] s_memread_r;
  logic [4:0]          s_rd_r [0:FWD_STAGES];

  logic stall_hit_s;
  logic stall_s;

  function automatic logic writes_reg(input logic valid, input logic regwrite,
                                      input logic [4:0] rd, input logic [4:0] rs);
    return valid && regwrite && (rd != 5'd0) && (rd == rs);
  endfunction

  // A producer whose result is not yet forwardable when ID would enter EX forces a stall
  always_comb begin
    stall_hit_s = 1'b0;
    for (int j = 0; j <= FWD_STAGES; j++) begin
      if (((id_use_rs1 && writes_reg(s_valid_r[j], s_regwrite_r[j], s_rd_r[j], id_rs1)) ||
           (id_use_rs2 && writes_reg(s_valid_r[j], s_regwrite_r[j], s_rd_r[j], id_rs2))) &&
          (j + 1 < (s_memread_r[j] ? 1 + LOAD_LAT : 1))) begin
        stall_hit_s = 1'b1;
      end else begin
        stall_hit_s = stall_hit_s;
      end
    end
    stall_s = id_valid && !redirect && stall_hit_s;
  end

  // Pipeline enables: hold beats redirect, redirect beats stall
  always_comb begin
    if (hold) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
    end else if (redirect) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall_s) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
    end
  end

  // Forward selects: scanning oldest to youngest lets the youngest producer win
  always_comb begin
    fwd_sel_a = {SELW{1'b0}};
    fwd_sel_b = {SELW{1'b0}};
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (writes_reg(s_valid_r[k], s_regwrite_r[k], s_rd_r[k], ex_rs1)) begin
        fwd_sel_a = SELW'(k);
      end else begin
        fwd_sel_a = fwd_sel_a;
      end
      if (writes_reg(s_valid_r[k], s_regwrite_r[k], s_rd_r[k], ex_rs2)) begin
        fwd_sel_b = SELW'(k);
      end else begin
        fwd_sel_b = fwd_sel_b;
      end
    end
  end

  // Operand muxes driven by the selects
  always_comb begin
    ex_opa = rf_a;
    ex_opb = rf_b;
    for (int k = 1; k <= FWD_STAGES; k++) begin
      if (fwd_sel_a == SELW'(k)) begin
        ex_opa = fwd_data[(k-1)*XLEN +: XLEN];
      end else begin
        ex_opa = ex_opa;
      end
      if (fwd_sel_b == SELW'(k)) begin
        ex_opb = fwd_data[(k-1)*XLEN +: XLEN];
      end else begin
        ex_opb = ex_opb;
      end
    end
  end

  // Shadow tag pipeline; a redirect kills everything younger than the resolving slot
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      s_valid_r    <= '0;
      s_regwrite_r <= '0;
      s_memread_r  <= '0;
      for (int k = 0; k <= FWD_STAGES; k++) begin
        s_rd_r[k] <= 5'd0;
      end
    end else if (hold) begin
      s_valid_r <= s_valid_r;
    end else begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        s_valid_r[k]    <= s_valid_r[k-1];
        s_regwrite_r[k] <= s_regwrite_r[k-1];
        s_memread_r[k]  <= s_memread_r[k-1];
        s_rd_r[k]       <= s_rd_r[k-1];
      end
      if (redirect) begin
        for (int k = 0; k <= REDIRECT_SLOT; k++) begin
          s_valid_r[k] <= 1'b0;
        end
      end else begin
        s_valid_r[0]    <= id_valid && !stall_s;
        s_regwrite_r[0] <= id_regwrite;
        s_memread_r[0]  <= id_memread;
        s_rd_r[0]       <= id_rd;
      end
    end
  end

`ifdef HAZ_STATS_EN
  logic [31:0] stall_count_r;
  logic [31:0] flush_count_r;

  // Event counters, frozen while the pipe is held
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      stall_count_r <= 32'd0;
      flush_count_r <= 32'd0;
    end else if (!hold) begin
      stall_count_r <= stall_count_r + (stall_s ? 32'd1 : 32'd0);
      flush_count_r <= flush_count_r + (redirect ? 32'd1 : 32'd0);
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall_count = stall_count_r;
  assign flush_count = flush_count_r;
`else
  assign stall_count = 32'd0;
  assign flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a LOAD_LAT=1 instance and a LOAD_LAT=2 instance share stimulus.
module tb_pipe_hazard_ctrl;
  localparam int XLEN = 32;
  localparam int FS   = 3;
`ifdef HAZ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic CLOCK = 1'b0;
  logic RST_n;
  logic hold, id_valid, id_regwrite, id_memread, id_use_rs1, id_use_rs2, redirect;
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2;
  logic [XLEN-1:0] rf_a, rf_b;
  logic [FS*XLEN-1:0] fwd_data;

  logic pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0] fwd_sel_a, fwd_sel_b;
  logic [XLEN-1:0] ex_opa, ex_opb;
  logic [31:0] stall_count, flush_count;

  logic pc_write2, ifid_write2, ifid_flush2, idex_bubble2;
  logic [1:0] fwd_sel_a2, fwd_sel_b2;
  logic [XLEN-1:0] ex_opa2, ex_opb2;
  logic [31:0] stall_count2, flush_count2;

  int errors = 0;
  int checks = 0;

  always #5 CLOCK = ~CLOCK;

  pipe_hazard_ctrl #(.XLEN(XLEN), .FWD_STAGES(FS), .LOAD_LAT(1), .REDIRECT_SLOT(1)) dut (
    .CLOCK(CLOCK), .RST_n(RST_n), .hold(hold), .id_valid(id_valid), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .rf_a(rf_a), .rf_b(rf_b), .fwd_data(fwd_data), .redirect(redirect),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .ex_opa(ex_opa), .ex_opb(ex_opb),
    .stall_count(stall_count), .flush_count(flush_count));

  pipe_hazard_ctrl #(.XLEN(XLEN), .FWD_STAGES(FS), .LOAD_LAT(2), .REDIRECT_SLOT(1)) dut2 (
    .CLOCK(CLOCK), .RST_n(RST_n), .hold(hold), .id_valid(id_valid), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .rf_a(rf_a), .rf_b(rf_b), .fwd_data(fwd_data), .redirect(redirect),
    .pc_write(pc_write2), .ifid_write(ifid_write2), .ifid_flush(ifid_flush2), .idex_bubble(idex_bubble2),
    .fwd_sel_a(fwd_sel_a2), .fwd_sel_b(fwd_sel_b2), .ex_opa(ex_opa2), .ex_opb(ex_opb2),
    .stall_count(stall_count2), .flush_count(flush_count2));

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic id_none;
    id_valid = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
  endtask

  task automatic id_instr(input logic rw, input logic mr, input logic [4:0] rd,
                          input logic u1, input logic [4:0] r1, input logic u2, input logic [4:0] r2);
    id_valid = 1'b1; id_regwrite = rw; id_memread = mr; id_rd = rd;
    id_use_rs1 = u1; id_rs1 = r1; id_use_rs2 = u2; id_rs2 = r2;
  endtask

  task automatic apply_reset;
    RST_n = 1'b0;
    hold = 1'b0; redirect = 1'b0;
    id_none();
    ex_rs1 = 5'd0; ex_rs2 = 5'd0;
    rf_a = 32'h0000_A0A0; rf_b = 32'h0000_B0B0;
    fwd_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    tick(); tick();
    RST_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    apply_reset();
    RST_n = 1'b0;
    ex_rs1 = 5'd5; ex_rs2 = 5'd6; redirect = 1'b1;
    #1;
    checks++; if (ifid_flush !== 1'b1) begin errors++; $display("FAIL rst_flush_follows_redirect got %b exp 1", ifid_flush); end
    redirect = 1'b0;
    #1;
    checks++; if ({pc_write, ifid_write, ifid_flush, idex_bubble} !== 4'b1100) begin errors++; $display("FAIL rst_ctrl got %b exp 1100", {pc_write, ifid_write, ifid_flush, idex_bubble}); end
    checks++; if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin errors++; $display("FAIL rst_sel got %0d/%0d exp 0/0", fwd_sel_a, fwd_sel_b); end
    checks++; if (ex_opa !== 32'h0000_A0A0 || ex_opb !== 32'h0000_B0B0) begin errors++; $display("FAIL rst_ops got %h/%h exp 0000a0a0/0000b0b0", ex_opa, ex_opb); end
    checks++; if (stall_count !== 32'd0 || flush_count !== 32'd0) begin errors++; $display("FAIL rst_counters got %0d/%0d exp 0/0", stall_count, flush_count); end
    RST_n = 1'b1;
  endtask

  task automatic test_load_use;
    apply_reset();
    id_instr(1'b1, 1'b1, 5'd5, 1'b1, 5'd1, 1'b0, 5'd0);
    #1;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_first_nostall got %b exp 1", pc_write); end
    tick();
    id_instr(1'b1, 1'b0, 5'd6, 1'b1, 5'd5, 1'b1, 5'd2);
    #1;
    checks++; if ({pc_write, ifid_write, ifid_flush, idex_bubble} !== 4'b0001) begin errors++; $display("FAIL lu_stall_ctrl got %b exp 0001", {pc_write, ifid_write, ifid_flush, idex_bubble}); end
    tick(); #1;
    checks++; if ({pc_write, idex_bubble} !== 2'b10) begin errors++; $display("FAIL lu_stall_ends got %b exp 10", {pc_write, idex_bubble}); end
    tick();
    id_none();
    ex_rs1 = 5'd5; ex_rs2 = 5'd2;
    #1;
    checks++; if (fwd_sel_a !== 2'd2 || ex_opa !== 32'h2222_2222) begin errors++; $display("FAIL lu_fwd_a got sel %0d op %h exp 2 22222222", fwd_sel_a, ex_opa); end
    checks++; if (fwd_sel_b !== 2'd0 || ex_opb !== 32'h0000_B0B0) begin errors++; $display("FAIL lu_fwd_b got sel %0d op %h exp 0 0000b0b0", fwd_sel_b, ex_opb); end
    checks++; if (stall_count !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL lu_stall_count got %0d exp %0d", stall_count, STATS ? 1 : 0); end
  endtask

  task automatic test_load_use_lat2;
    apply_reset();
    id_instr(1'b1, 1'b1, 5'd5, 1'b1, 5'd1, 1'b0, 5'd0);
    tick();
    id_instr(1'b1, 1'b0, 5'd6, 1'b1, 5'd5, 1'b0, 5'd0);
    #1;
    checks++; if ({pc_write2, idex_bubble2} !== 2'b01) begin errors++; $display("FAIL l2_stall1 got %b exp 01", {pc_write2, idex_bubble2}); end
    tick(); #1;
    checks++; if ({pc_write2, idex_bubble2} !== 2'b01) begin errors++; $display("FAIL l2_stall2 got %b exp 01", {pc_write2, idex_bubble2}); end
    tick(); #1;
    checks++; if ({pc_write2, idex_bubble2} !== 2'b10) begin errors++; $display("FAIL l2_stall_ends got %b exp 10", {pc_write2, idex_bubble2}); end
    tick();
    id_none();
    ex_rs1 = 5'd5;
    #1;
    checks++; if (fwd_sel_a2 !== 2'd3 || ex_opa2 !== 32'h3333_3333) begin errors++; $display("FAIL l2_fwd got sel %0d op %h exp 3 33333333", fwd_sel_a2, ex_opa2); end
    checks++; if (stall_count2 !== (STATS ? 32'd2 : 32'd0)) begin errors++; $display("FAIL l2_stall_count got %0d exp %0d", stall_count2, STATS ? 2 : 0); end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    fwd_data[31:0] = 32'h0000_0011;
    id_instr(1'b1, 1'b0, 5'd3, 1'b1, 5'd1, 1'b0, 5'd0);
    tick();
    id_instr(1'b1, 1'b0, 5'd4, 1'b1, 5'd3, 1'b1, 5'd3);
    #1;
    checks++; if ({pc_write, idex_bubble} !== 2'b10) begin errors++; $display("FAIL b2b_nostall got %b exp 10", {pc_write, idex_bubble}); end
    tick();
    id_none();
    ex_rs1 = 5'd3; ex_rs2 = 5'd3;
    #1;
    checks++; if (fwd_sel_a !== 2'd1 || fwd_sel_b !== 2'd1) begin errors++; $display("FAIL b2b_sel got %0d/%0d exp 1/1", fwd_sel_a, fwd_sel_b); end
    checks++; if (ex_opa !== 32'h0000_0011 || ex_opb !== 32'h0000_0011) begin errors++; $display("FAIL b2b_ops got %h/%h exp 00000011", ex_opa, ex_opb); end
  endtask

  task automatic test_priority;
    apply_reset();
    fwd_data = {32'h0000_00CC, 32'h0000_00BB, 32'h0000_00AA};
    id_instr(1'b1, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    id_instr(1'b1, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    id_instr(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    id_none();
    ex_rs1 = 5'd7;
    #1;
    checks++; if (fwd_sel_a !== 2'd1 || ex_opa !== 32'h0000_00AA) begin errors++; $display("FAIL prio_youngest got sel %0d op %h exp 1 000000aa", fwd_sel_a, ex_opa); end
    tick();
    ex_rs2 = 5'd0;
    #1;
    checks++; if (fwd_sel_a !== 2'd2 || ex_opa !== 32'h0000_00BB) begin errors++; $display("FAIL prio_shifted got sel %0d op %h exp 2 000000bb", fwd_sel_a, ex_opa); end
    checks++; if (fwd_sel_b !== 2'd0 || ex_opb !== 32'h0000_B0B0) begin errors++; $display("FAIL prio_x0 got sel %0d op %h exp 0 0000b0b0", fwd_sel_b, ex_opb); end
  endtask

  task automatic test_redirect;
    apply_reset();
    id_instr(1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    id_instr(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    id_instr(1'b1, 1'b0, 5'd6, 1'b1, 5'd5, 1'b0, 5'd0);
    redirect = 1'b1;
    #1;
    checks++; if ({pc_write, ifid_write, ifid_flush, idex_bubble} !== 4'b1111) begin errors++; $display("FAIL redir_ctrl got %b exp 1111", {pc_write, ifid_write, ifid_flush, idex_bubble}); end
    tick();
    redirect = 1'b0;
    ex_rs1 = 5'd9; ex_rs2 = 5'd5;
    #1;
    checks++; if ({pc_write, idex_bubble} !== 2'b10) begin errors++; $display("FAIL redir_load_flushed got %b exp 10", {pc_write, idex_bubble}); end
    checks++; if (fwd_sel_a !== 2'd2 || fwd_sel_b !== 2'd0) begin errors++; $display("FAIL redir_slots got %0d/%0d exp 2/0", fwd_sel_a, fwd_sel_b); end
    checks++; if (flush_count !== (STATS ? 32'd1 : 32'd0) || stall_count !== 32'd0) begin errors++; $display("FAIL redir_counts got %0d/%0d exp %0d/0", flush_count, stall_count, STATS ? 1 : 0); end
  endtask

  task automatic test_hold;
    apply_reset();
    id_instr(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    id_instr(1'b1, 1'b0, 5'd6, 1'b1, 5'd5, 1'b0, 5'd0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({pc_write, ifid_write, ifid_flush, idex_bubble} !== 4'b0000) begin errors++; $display("FAIL hold_ctrl cycle %0d got %b exp 0000", i, {pc_write, ifid_write, ifid_flush, idex_bubble}); end
      tick();
    end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL hold_stall_count got %0d exp 0", stall_count); end
    hold = 1'b0;
    #1;
    checks++; if ({pc_write, ifid_write, idex_bubble} !== 3'b001) begin errors++; $display("FAIL hold_resume_stall got %b exp 001", {pc_write, ifid_write, idex_bubble}); end
    tick(); #1;
    checks++; if ({pc_write, idex_bubble} !== 2'b10) begin errors++; $display("FAIL hold_stall_done got %b exp 10", {pc_write, idex_bubble}); end
    checks++; if (stall_count !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL hold_count_after got %0d exp %0d", stall_count, STATS ? 1 : 0); end
  endtask

  task automatic test_reset_mid_stall;
    apply_reset();
    id_instr(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    id_instr(1'b1, 1'b0, 5'd6, 1'b1, 5'd5, 1'b0, 5'd0);
    ex_rs1 = 5'd5;
    #1;
    checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL mid_pre_stall got %b exp 1", idex_bubble); end
    #2;
    RST_n = 1'b0;
    #1;
    checks++; if ({pc_write, ifid_write, ifid_flush, idex_bubble} !== 4'b1100) begin errors++; $display("FAIL mid_rst_ctrl got %b exp 1100", {pc_write, ifid_write, ifid_flush, idex_bubble}); end
    checks++; if (fwd_sel_a !== 2'd0 || ex_opa !== 32'h0000_A0A0) begin errors++; $display("FAIL mid_rst_fwd got sel %0d op %h exp 0 0000a0a0", fwd_sel_a, ex_opa); end
    checks++; if (stall_count !== 32'd0 || flush_count !== 32'd0) begin errors++; $display("FAIL mid_rst_counters got %0d/%0d exp 0/0", stall_count, flush_count); end
    tick();
    RST_n = 1'b1;
  endtask

  initial begin
    RST_n = 1'b0;
    test_reset();
    test_load_use();
    test_load_use_lat2();
    test_back_to_back();
    test_priority();
    test_redirect();
    test_hold();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
